// File: rtl/bit_row_packer.sv
// Serial-to-parallel row packer: collects bit_in into rows of up to COLS bits
// and writes each completed row to a downstream row memory, one frame of ROWS rows per start.
//
// state | meaning
// IDLE  | waiting for start, bit_ready low
// SHIFT | accepting bits of the current row
// WRITE | one-cycle row_we strobe for the assembled row
// DONE  | one-cycle done pulse, then back to IDLE
module bit_row_packer #(
  parameter int ROWS     = 7,
  parameter int COLS     = 8,
  parameter int TRI_BASE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            bit_in,
  input  logic            bit_valid,
  output logic            bit_ready,
  output logic            row_we,
  output logic [2:0]      row_addr,
  output logic [COLS-1:0] row_data,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(COLS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

  state_t          state_q;
  logic [2:0]      row_q;
  logic [CW-1:0]   col_q;
  logic [COLS-1:0] row_reg_q;
  logic [COLS-1:0] row_reg_d;
  logic [2:0]      row_addr_q;
  logic [COLS-1:0] row_data_q;
  logic [CW-1:0]   last_col;
  logic            accept;

  // Triangular fill shortens early rows; TRI_BASE of 0 means every row is full width.
  function automatic int row_len(input logic [2:0] r);
    int l;
    l = COLS;
    if (TRI_BASE > 0 && int'(r) + TRI_BASE < COLS) l = int'(r) + TRI_BASE;
    return l;
  endfunction

  assign last_col = CW'(row_len(row_q) - 1);
  assign accept   = (state_q == SHIFT) && bit_valid;

  always_comb begin
    row_reg_d = row_reg_q;
    for (int j = 0; j < COLS; j++) begin
      if (col_q == CW'(j)) row_reg_d[j] = bit_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= 3'd0;
      col_q      <= '0;
      row_reg_q  <= '0;
      row_addr_q <= 3'd0;
      row_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SHIFT;
            row_q     <= 3'd0;
            col_q     <= '0;
            row_reg_q <= '0;
          end
        end
        SHIFT: begin
          if (accept) begin
            row_reg_q <= row_reg_d;
            col_q     <= col_q + CW'(1);
            if (col_q == last_col) begin
              state_q    <= WRITE;
              row_addr_q <= row_q;
              row_data_q <= row_reg_d;
            end
          end
        end
        WRITE: begin
          if (row_q == 3'(ROWS - 1)) begin
            state_q <= DONE;
          end else begin
            state_q   <= SHIFT;
            row_q     <= row_q + 3'd1;
            col_q     <= '0;
            row_reg_q <= '0;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bit_ready = (state_q == SHIFT);
  assign row_we    = (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign row_addr  = row_addr_q;
  assign row_data  = row_data_q;

endmodule

// File: tb/tb_bit_row_packer.sv
// Directed bench for bit_row_packer: default-geometry instance plus a TRI_BASE=4 instance,
// driven one at a time through a shared stimulus/monitor task.
module tb_bit_row_packer;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic start_v, valid_v, bit_in_v;

  logic       a_ready, a_we, a_busy, a_done;
  logic [2:0] a_addr;
  logic [7:0] a_data;
  logic       t_ready, t_we, t_busy, t_done;
  logic [2:0] t_addr;
  logic [7:0] t_data;

  logic       ready_m, we_m, busy_m, done_m;
  logic [2:0] addr_m;
  logic [7:0] data_m;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int nwr;
  logic [2:0] wr_addr [16];
  logic [7:0] wr_data [16];

  always #5 clk = ~clk;

  bit_row_packer dut (
    .clk(clk), .rst(rst), .start(start_v && !sel), .bit_in(bit_in_v),
    .bit_valid(valid_v && !sel), .bit_ready(a_ready), .row_we(a_we),
    .row_addr(a_addr), .row_data(a_data), .busy(a_busy), .done(a_done)
  );

  bit_row_packer #(.ROWS(7), .COLS(8), .TRI_BASE(4)) dut_tri (
    .clk(clk), .rst(rst), .start(start_v && sel), .bit_in(bit_in_v),
    .bit_valid(valid_v && sel), .bit_ready(t_ready), .row_we(t_we),
    .row_addr(t_addr), .row_data(t_data), .busy(t_busy), .done(t_done)
  );

  assign ready_m = sel ? t_ready : a_ready;
  assign we_m    = sel ? t_we    : a_we;
  assign busy_m  = sel ? t_busy  : a_busy;
  assign done_m  = sel ? t_done  : a_done;
  assign addr_m  = sel ? t_addr  : a_addr;
  assign data_m  = sel ? t_data  : a_data;

  // Runs one frame from a start pulse; lat = edges from the start-sampling edge to the done cycle.
  task automatic run_frame(input bit use_tri, input bit alt, input int stall_hs, input int rst_hs,
                           input int inj_a, input int inj_b, output int lat, output int hs);
    int  edges;
    int  stall_left;
    bit  hs_now;
    bit  stalled;
    sel = use_tri;
    lat = -1; hs = 0; nwr = 0; stall_left = 0; stalled = 0; edges = 0;
    bit_in_v = 1'b1; valid_v = 1'b1; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      hs_now = valid_v && ready_m;
      if (we_m) begin
        if (nwr < 16) begin
          wr_addr[nwr] = addr_m;
          wr_data[nwr] = data_m;
        end
        nwr++;
        cmp_cnt++;
        if (ready_m !== 1'b0) begin
          err_cnt++;
          $display("FAIL ready_in_write: got %b want 0", ready_m);
        end
      end
      if (done_m) begin
        cmp_cnt++;
        if (ready_m !== 1'b0 || we_m !== 1'b0) begin
          err_cnt++;
          $display("FAIL ready_we_in_done: got ready=%b we=%b want 0 0", ready_m, we_m);
        end
        lat = edges;
        @(posedge clk); #1;
        start_v = 1'b0;
        break;
      end
      @(posedge clk); #1;
      edges++;
      if (hs_now) begin
        hs++;
        if (alt) bit_in_v = ~bit_in_v;
      end
      if (rst_hs > 0 && hs == rst_hs) begin
        rst = 1'b1;
        break;
      end
      start_v = (edges == inj_a) || (edges == inj_b);
      if (!stalled && stall_hs > 0 && hs == stall_hs) begin
        valid_v = 1'b0; stall_left = 3; stalled = 1;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) valid_v = 1'b1;
      end
    end
    start_v = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_v = 1'b0; valid_v = 1'b1; bit_in_v = 1'b1; sel = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      cmp_cnt++;
      if ({busy_m, ready_m, we_m, done_m, addr_m, data_m} !== 15'd0) begin
        err_cnt++;
        $display("FAIL reset_outputs sel=%0d: got busy=%b rdy=%b we=%b done=%b addr=%0d data=%h want all 0",
                 s, busy_m, ready_m, we_m, done_m, addr_m, data_m);
      end
    end
    sel = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_idle_valid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if ({busy_m, ready_m, we_m, done_m} !== 4'd0) begin
        err_cnt++;
        $display("FAIL idle_valid: got busy=%b rdy=%b we=%b done=%b want 0000", busy_m, ready_m, we_m, done_m);
      end
    end
    valid_v = 1'b0;
  endtask

  task automatic test_full_frame();
    int lat, hs;
    run_frame(1'b0, 1'b1, -1, -1, -1, -1, lat, hs);
    cmp_cnt++;
    if (nwr !== 7) begin err_cnt++; $display("FAIL full_nwr: got %0d want 7", nwr); end
    for (int i = 0; i < 7 && i < nwr; i++) begin
      cmp_cnt++;
      if (wr_addr[i] !== 3'(i) || wr_data[i] !== 8'h55) begin
        err_cnt++;
        $display("FAIL full_row%0d: got addr=%0d data=%h want addr=%0d data=55", i, wr_addr[i], wr_data[i], i);
      end
    end
    cmp_cnt++;
    if (lat !== 63) begin err_cnt++; $display("FAIL full_latency: got %0d want 63", lat); end
    cmp_cnt++;
    if (hs !== 56) begin err_cnt++; $display("FAIL full_handshakes: got %0d want 56", hs); end
    @(negedge clk);
    cmp_cnt++;
    if (busy_m !== 1'b0 || we_m !== 1'b0 || addr_m !== 3'd6 || data_m !== 8'h55) begin
      err_cnt++;
      $display("FAIL full_hold: got busy=%b we=%b addr=%0d data=%h want 0 0 6 55", busy_m, we_m, addr_m, data_m);
    end
  endtask

  task automatic test_triangular();
    int lat, hs;
    logic [7:0] exp_t [7];
    exp_t = '{8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
    run_frame(1'b1, 1'b0, -1, -1, -1, -1, lat, hs);
    cmp_cnt++;
    if (nwr !== 7) begin err_cnt++; $display("FAIL tri_nwr: got %0d want 7", nwr); end
    for (int i = 0; i < 7 && i < nwr; i++) begin
      cmp_cnt++;
      if (wr_addr[i] !== 3'(i) || wr_data[i] !== exp_t[i]) begin
        err_cnt++;
        $display("FAIL tri_row%0d: got addr=%0d data=%h want addr=%0d data=%h", i, wr_addr[i], wr_data[i], i, exp_t[i]);
      end
    end
    cmp_cnt++;
    if (hs !== 46) begin err_cnt++; $display("FAIL tri_handshakes: got %0d want 46", hs); end
    cmp_cnt++;
    if (lat !== 53) begin err_cnt++; $display("FAIL tri_latency: got %0d want 53", lat); end
    sel = 1'b0;
  endtask

  task automatic test_stall();
    int lat, hs;
    run_frame(1'b0, 1'b1, 19, -1, -1, -1, lat, hs);
    cmp_cnt++;
    if (nwr !== 7) begin err_cnt++; $display("FAIL stall_nwr: got %0d want 7", nwr); end
    for (int i = 0; i < 7 && i < nwr; i++) begin
      cmp_cnt++;
      if (wr_addr[i] !== 3'(i) || wr_data[i] !== 8'h55) begin
        err_cnt++;
        $display("FAIL stall_row%0d: got addr=%0d data=%h want addr=%0d data=55", i, wr_addr[i], wr_data[i], i);
      end
    end
    cmp_cnt++;
    if (lat !== 66) begin err_cnt++; $display("FAIL stall_latency: got %0d want 66", lat); end
  endtask

  task automatic test_start_ignored();
    int lat, hs;
    run_frame(1'b0, 1'b1, -1, -1, 5, 63, lat, hs);
    cmp_cnt++;
    if (nwr !== 7) begin err_cnt++; $display("FAIL start_ign_nwr: got %0d want 7", nwr); end
    cmp_cnt++;
    if (lat !== 63) begin err_cnt++; $display("FAIL start_ign_latency: got %0d want 63", lat); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if (busy_m !== 1'b0 || we_m !== 1'b0) begin
        err_cnt++;
        $display("FAIL start_ign_idle: got busy=%b we=%b want 0 0", busy_m, we_m);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int lat, hs;
    bit hit4;
    run_frame(1'b0, 1'b1, -1, 35, -1, -1, lat, hs);
    #1;
    cmp_cnt++;
    if ({busy_m, ready_m, we_m, done_m, addr_m, data_m} !== 15'd0) begin
      err_cnt++;
      $display("FAIL midrst_outputs: got busy=%b rdy=%b we=%b done=%b addr=%0d data=%h want all 0",
               busy_m, ready_m, we_m, done_m, addr_m, data_m);
    end
    hit4 = 0;
    for (int i = 0; i < nwr && i < 16; i++) if (wr_addr[i] == 3'd4) hit4 = 1;
    cmp_cnt++;
    if (nwr !== 4 || hit4) begin
      err_cnt++;
      $display("FAIL midrst_writes: got %0d writes addr4=%b want 4 writes addr4=0", nwr, hit4);
    end
    @(negedge clk);
    rst = 1'b0;
    valid_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if (busy_m !== 1'b0 || ready_m !== 1'b0) begin
        err_cnt++;
        $display("FAIL midrst_needs_start: got busy=%b rdy=%b want 0 0", busy_m, ready_m);
      end
    end
    run_frame(1'b0, 1'b1, -1, -1, -1, -1, lat, hs);
    cmp_cnt++;
    if (nwr !== 7 || lat !== 63) begin
      err_cnt++;
      $display("FAIL midrst_reframe: got nwr=%0d lat=%0d want 7 63", nwr, lat);
    end
    for (int i = 0; i < 7 && i < nwr; i++) begin
      cmp_cnt++;
      if (wr_addr[i] !== 3'(i) || wr_data[i] !== 8'h55) begin
        err_cnt++;
        $display("FAIL midrst_row%0d: got addr=%0d data=%h want addr=%0d data=55", i, wr_addr[i], wr_data[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_valid();
    test_full_frame();
    test_triangular();
    test_stall();
    test_start_ignored();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
